// File: rtl/path_check_pkg.sv
// Shared definitions for the path capture checker: FSM state encoding,
// violation log depth and the largest supported launch-to-capture latency.
package path_check_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int LOG_DEPTH = 4;
   localparam int LAT_MAX   = 15;

endpackage

// File: rtl/capture_delay_line.sv
// LAT-stage shift register carrying {valid, expected value} from the launch
// side to the capture comparator. any_valid reports whether any entry will
// still be pending after the current cycle's capture, which is what the
// drain logic needs to decide that the run has finished.
module capture_delay_line #(
   parameter int W   = 1,
   parameter int LAT = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_exp,
   output logic         out_valid,
   output logic [W-1:0] out_exp,
   output logic         any_valid
);

   logic [LAT-1:0] valid_q;
   logic [W-1:0]   exp_q [LAT];

   // Shift every entry one stage toward the comparator each cycle; reset flushes in-flight entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            exp_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= in_valid;
         exp_q[0]   <= in_exp;
         for (int i = 1; i < LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            exp_q[i]   <= exp_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[LAT-1];
   assign out_exp   = exp_q[LAT-1];

   // Entries that survive this cycle: the incoming one plus all but the last stage
   always_comb begin
      any_valid = in_valid;
      for (int i = 0; i < LAT - 1; i++) begin
         any_valid = any_valid | valid_q[i];
      end
   end

endmodule

// File: rtl/path_capture_checker.sv
// Capture-side checker for a launched timing path. Each accepted launch
// carries its expected endpoint value down a LAT-stage delay line; when it
// emerges, cap_in is compared against it and the vector/violation counters
// update (saturating). first_viol remembers the index of the first miss.
// Optional feature: define VIOL_LOG_EN to keep a 4-entry log of the first
// four violations {idx, got, exp}, read combinationally through log_sel.
module path_capture_checker
   import path_check_pkg::*;
#(
   parameter int W     = 1,
   parameter int LAT   = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             launch_valid,
   input  logic [W-1:0]     launch_exp,
   output logic             launch_ready,
   input  logic [W-1:0]     cap_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] viol_cnt,
   output logic [CNT_W-1:0] first_viol
`ifdef VIOL_LOG_EN
   ,
   input  logic [1:0]       log_sel,
   output logic [CNT_W-1:0] log_idx,
   output logic [W-1:0]     log_got,
   output logic [W-1:0]     log_exp,
   output logic [2:0]       log_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t       state;
   logic         accept;
   logic         cmp_valid;
   logic [W-1:0] cmp_exp;
   logic         mismatch;
   logic         any_valid;
   logic         run_start;

   assign launch_ready = (state == S_RUN);
   assign busy         = (state == S_RUN) || (state == S_DRAIN);
   assign done         = (state == S_DONE);
   assign accept       = launch_valid && launch_ready;
   assign run_start    = (state == S_IDLE) && start;
   assign mismatch     = cmp_valid && (cap_in != cmp_exp);

   capture_delay_line #(
      .W   (W),
      .LAT (LAT)
   ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept),
      .in_exp    (launch_exp),
      .out_valid (cmp_valid),
      .out_exp   (cmp_exp),
      .any_valid (any_valid)
   );

   // Run control: stop still lets the same-cycle launch in, drain waits for the delay line to empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start)      state <= S_RUN;
            S_RUN:   if (stop)       state <= S_DRAIN;
            S_DRAIN: if (!any_valid) state <= S_DONE;
            S_DONE:  if (clear)      state <= S_IDLE;
            default:                 state <= S_IDLE;
         endcase
      end
   end

   // Saturating vector/violation counters; first_viol latches the pre-increment index of the first miss
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_cnt    <= '0;
         viol_cnt   <= '0;
         first_viol <= CNT_MAX;
      end else if (run_start) begin
         vec_cnt    <= '0;
         viol_cnt   <= '0;
         first_viol <= CNT_MAX;
      end else if (cmp_valid) begin
         if (vec_cnt != CNT_MAX) begin
            vec_cnt <= vec_cnt + 1'b1;
         end
         if (mismatch) begin
            if (viol_cnt != CNT_MAX) begin
               viol_cnt <= viol_cnt + 1'b1;
            end
            if (viol_cnt == '0) begin
               first_viol <= vec_cnt;
            end
         end
      end
   end

`ifdef VIOL_LOG_EN
   logic [CNT_W-1:0] log_idx_q [LOG_DEPTH];
   logic [W-1:0]     log_got_q [LOG_DEPTH];
   logic [W-1:0]     log_exp_q [LOG_DEPTH];
   logic [2:0]       log_cnt_q;

   // Record the first LOG_DEPTH violations; later ones are dropped and the count stays full
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         log_cnt_q <= '0;
         for (int i = 0; i < LOG_DEPTH; i++) begin
            log_idx_q[i] <= '0;
            log_got_q[i] <= '0;
            log_exp_q[i] <= '0;
         end
      end else if (run_start) begin
         log_cnt_q <= '0;
         for (int i = 0; i < LOG_DEPTH; i++) begin
            log_idx_q[i] <= '0;
            log_got_q[i] <= '0;
            log_exp_q[i] <= '0;
         end
      end else if (mismatch && (log_cnt_q < 3'(LOG_DEPTH))) begin
         log_idx_q[log_cnt_q[1:0]] <= vec_cnt;
         log_got_q[log_cnt_q[1:0]] <= cap_in;
         log_exp_q[log_cnt_q[1:0]] <= cmp_exp;
         log_cnt_q                 <= log_cnt_q + 1'b1;
      end
   end

   assign log_idx = log_idx_q[log_sel];
   assign log_got = log_got_q[log_sel];
   assign log_exp = log_exp_q[log_sel];
   assign log_cnt = log_cnt_q;
`endif

endmodule

// File: tb/tb_path_capture_checker.sv
// Bench for path_capture_checker (W=1, LAT=2). A second instance with
// CNT_W=4 shares the stimulus to exercise counter saturation. Define
// VIOL_LOG_EN to also exercise the violation log.
module tb_path_capture_checker;

   localparam int W   = 1;
   localparam int LAT = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         clear = 1'b0;
   logic         launch_valid = 1'b0;
   logic [W-1:0] launch_exp = '0;
   logic [W-1:0] cap_in = '0;

   logic         launch_ready, busy, done;
   logic [15:0]  vec_cnt, viol_cnt, first_viol;
   logic         ready4, busy4, done4;
   logic [3:0]   vec4, viol4, first4;

`ifdef VIOL_LOG_EN
   logic [1:0]   log_sel = 2'd0;
   logic [15:0]  log_idx;
   logic [W-1:0] log_got, log_exp;
   logic [2:0]   log_cnt;
   logic [3:0]   log_idx4;
   logic [W-1:0] log_got4, log_exp4;
   logic [2:0]   log_cnt4;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   path_capture_checker #(.W(W), .LAT(LAT), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
      .launch_valid(launch_valid), .launch_exp(launch_exp), .launch_ready(launch_ready),
      .cap_in(cap_in), .busy(busy), .done(done),
      .vec_cnt(vec_cnt), .viol_cnt(viol_cnt), .first_viol(first_viol)
`ifdef VIOL_LOG_EN
      , .log_sel(log_sel), .log_idx(log_idx), .log_got(log_got), .log_exp(log_exp), .log_cnt(log_cnt)
`endif
   );

   path_capture_checker #(.W(W), .LAT(LAT), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
      .launch_valid(launch_valid), .launch_exp(launch_exp), .launch_ready(ready4),
      .cap_in(cap_in), .busy(busy4), .done(done4),
      .vec_cnt(vec4), .viol_cnt(viol4), .first_viol(first4)
`ifdef VIOL_LOG_EN
      , .log_sel(log_sel), .log_idx(log_idx4), .log_got(log_got4), .log_exp(log_exp4), .log_cnt(log_cnt4)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: launches are remembered with the cycle they were accepted in,
   // and each is judged against cap_in exactly LAT cycles later.
   localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;
   typedef struct { int t; logic [W-1:0] e; } launch_t;
   launch_t mq[$];
   int m_cycle = 0;
   int m_phase = P_IDLE;
   int m_vec = 0, m_viol = 0, m_first = -1;

   typedef struct {
      logic s, p, c, v, e, k;
      logic ready, busy, done;
      logic [15:0] vec, viol, first;
   } vec_t;
   vec_t tbl[17];

   function automatic vec_t mk(int s, int p, int c, int v, int e, int k,
                               int rd, int bz, int dn, int vc, int vl, int fv);
      vec_t r;
      r.s = s[0]; r.p = p[0]; r.c = c[0]; r.v = v[0]; r.e = e[0]; r.k = k[0];
      r.ready = rd[0]; r.busy = bz[0]; r.done = dn[0];
      r.vec = vc[15:0]; r.viol = vl[15:0]; r.first = fv[15:0];
      return r;
   endfunction

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic modelReset();
      mq.delete();
      m_phase = P_IDLE;
      m_vec = 0;
      m_viol = 0;
      m_first = -1;
   endtask

   task automatic modelStep();
      launch_t x;
      m_cycle++;
      if (mq.size() > 0 && mq[0].t == m_cycle - LAT) begin
         x = mq.pop_front();
         if (cap_in !== x.e) begin
            if (m_viol == 0) m_first = m_vec;
            m_viol++;
         end
         m_vec++;
      end
      if (m_phase == P_RUN && launch_valid) mq.push_back('{m_cycle, launch_exp});
      case (m_phase)
         P_IDLE:  if (start) begin m_phase = P_RUN; m_vec = 0; m_viol = 0; m_first = -1; end
         P_RUN:   if (stop) m_phase = P_DRAIN;
         P_DRAIN: if (mq.size() == 0) m_phase = P_DONE;
         default: if (clear) m_phase = P_IDLE;
      endcase
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic p, input logic c,
                                input logic v, input logic e, input logic k);
      @(negedge clk);
      start = s; stop = p; clear = c;
      launch_valid = v; launch_exp = e; cap_in = k;
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      start = 0; stop = 0; clear = 0; launch_valid = 0;
      rst = 1'b1;
      modelReset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic checkModel();
      checkOutput("m_ready", launch_ready, m_phase == P_RUN);
      checkOutput("m_busy",  busy, m_phase == P_RUN || m_phase == P_DRAIN);
      checkOutput("m_done",  done, m_phase == P_DONE);
      checkOutput("m_vec",   vec_cnt,  sat(m_vec, 65535));
      checkOutput("m_viol",  viol_cnt, sat(m_viol, 65535));
      checkOutput("m_first", first_viol, (m_first < 0) ? 65535 : sat(m_first, 65535));
      checkOutput("m4_ready", ready4, m_phase == P_RUN);
      checkOutput("m4_busy",  busy4, m_phase == P_RUN || m_phase == P_DRAIN);
      checkOutput("m4_done",  done4, m_phase == P_DONE);
      checkOutput("m4_vec",   vec4,  sat(m_vec, 15));
      checkOutput("m4_viol",  viol4, sat(m_viol, 15));
      checkOutput("m4_first", first4, (m_first < 0) ? 15 : sat(m_first, 15));
   endtask

   initial begin
      //     s p c v e k | rdy bsy dn  vec viol first
      tbl[0]  = mk(1,0,0,0,0,0, 1,1,0, 0,0,'hFFFF);
      tbl[1]  = mk(0,0,0,1,1,0, 1,1,0, 0,0,'hFFFF);
      tbl[2]  = mk(0,0,0,1,0,0, 1,1,0, 0,0,'hFFFF);
      tbl[3]  = mk(0,0,0,1,1,1, 1,1,0, 1,0,'hFFFF);
      tbl[4]  = mk(0,1,0,0,0,0, 0,1,0, 2,0,'hFFFF);
      tbl[5]  = mk(0,0,0,0,0,1, 0,0,1, 3,0,'hFFFF);
      tbl[6]  = mk(0,0,1,1,0,0, 0,0,0, 3,0,'hFFFF);
      tbl[7]  = mk(1,0,0,0,0,0, 1,1,0, 0,0,'hFFFF);
      tbl[8]  = mk(0,0,0,1,1,0, 1,1,0, 0,0,'hFFFF);
      tbl[9]  = mk(0,0,0,1,1,0, 1,1,0, 0,0,'hFFFF);
      tbl[10] = mk(0,0,0,1,0,1, 1,1,0, 1,0,'hFFFF);
      tbl[11] = mk(1,0,0,1,0,0, 1,1,0, 2,1,1);
      tbl[12] = mk(0,1,0,1,1,0, 0,1,0, 3,1,1);
      tbl[13] = mk(0,0,0,0,0,1, 0,1,0, 4,2,1);
      tbl[14] = mk(0,0,0,0,0,1, 0,0,1, 5,2,1);
      tbl[15] = mk(1,0,1,0,0,0, 0,0,0, 5,2,1);
      tbl[16] = mk(0,0,0,1,1,0, 0,0,0, 5,2,1);

      // Reset values while rst is held
      #12;
      checkOutput("rst_ready", launch_ready, 0);
      checkOutput("rst_busy",  busy, 0);
      checkOutput("rst_done",  done, 0);
      checkOutput("rst_vec",   vec_cnt, 0);
      checkOutput("rst_viol",  viol_cnt, 0);
      checkOutput("rst_first", first_viol, 16'hFFFF);
      checkOutput("rst_first4", first4, 4'hF);
      @(negedge clk);
      rst = 1'b0;
      modelReset();

      // Directed table: matching run, then a run with misses and stop on the final launch
      for (int i = 0; i < 17; i++) begin
         applyStimulus(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].v, tbl[i].e, tbl[i].k);
         checkOutput($sformatf("row%0d_ready", i), launch_ready, tbl[i].ready);
         checkOutput($sformatf("row%0d_busy", i),  busy, tbl[i].busy);
         checkOutput($sformatf("row%0d_done", i),  done, tbl[i].done);
         checkOutput($sformatf("row%0d_vec", i),   vec_cnt, tbl[i].vec);
         checkOutput($sformatf("row%0d_viol", i),  viol_cnt, tbl[i].viol);
         checkOutput($sformatf("row%0d_first", i), first_viol, tbl[i].first);
      end

      // Saturation: 20 mismatching vectors
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) applyStimulus(0, i == 19, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("sat_vec4",   vec4, 15);
      checkOutput("sat_viol4",  viol4, 15);
      checkOutput("sat_first4", first4, 0);
      checkOutput("sat_done4",  done4, 1);
      checkOutput("sat_vec",    vec_cnt, 20);
      checkOutput("sat_viol",   viol_cnt, 20);
      checkOutput("sat_done",   done, 1);
      applyStimulus(0, 0, 1, 0, 0, 0);

      // Async reset with two entries in flight
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("pre_rst_vec", vec_cnt, 2);
      #2;
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("arst_ready", launch_ready, 0);
      checkOutput("arst_busy",  busy, 0);
      checkOutput("arst_vec",   vec_cnt, 0);
      checkOutput("arst_viol",  viol_cnt, 0);
      checkOutput("arst_first", first_viol, 16'hFFFF);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_vec",  vec_cnt, 0);
      checkOutput("post_rst_viol", viol_cnt, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_run_vec", vec_cnt, 0);

      // Randomized run against the reference model
      doReset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            doReset();
            checkOutput("rand_rst_vec", vec_cnt, 0);
         end else begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checkModel();
         end
      end

`ifdef VIOL_LOG_EN
      // Violation log: misses at idx 0,2,3,5,6,7; only the first four are kept
      begin : log_test
         logic vmask [8];
         int   want_idx [4];
         int   j;
         logic ee, kk;
         vmask = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
         want_idx = '{0, 2, 3, 5};
         doReset();
         applyStimulus(1, 0, 0, 0, 0, 0);
         for (int s = 1; s <= 10; s++) begin
            j  = s - 3;
            ee = (s <= 8) ? 1'((s - 1) % 2) : 1'b0;
            kk = 1'b0;
            if (j >= 0) kk = vmask[j] ? ~1'(j % 2) : 1'(j % 2);
            applyStimulus(0, s == 8, 0, s <= 8, ee, kk);
         end
         checkOutput("log_cnt",  log_cnt, 4);
         checkOutput("log_viol", viol_cnt, 6);
         checkOutput("log_done", done, 1);
         for (int s = 0; s < 4; s++) begin
            log_sel = 2'(s);
            #1;
            checkOutput($sformatf("log%0d_idx", s), log_idx, want_idx[s]);
            checkOutput($sformatf("log%0d_got", s), log_got, ~1'(want_idx[s] % 2));
            checkOutput($sformatf("log%0d_exp", s), log_exp, 1'(want_idx[s] % 2));
         end
         checkOutput("log_cnt4", log_cnt4, 4);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
